crc_serial_engine: RTL and testbench

Parametrised bit-serial CRC generator/checker, successor to the fixed 5-bit/4-bit-word CRC block. It accepts data words over a valid/ready handshake and shifts them one bit per clock through a Galois LFSR of configurable width and polynomial. Multi-word messages accumulate into one CRC, delimited by `in_last`. It reports the final remainder and a zero-remainder check flag, and sits between the packet framer and the link serializer.

---
 rtl/crc_pkg.sv | 8 +
 rtl/crc_lfsr_step.sv | 14 +
 rtl/crc_serial_engine.sv | 68 ++++++
 tb/tb_crc_serial_engine.sv | 138 +++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// crc_pkg: shared state encoding and named CRC polynomials for the serial CRC engine
package crc_pkg;
  typedef enum logic {IDLE, SHIFT} crc_state_t;
  localparam logic [4:0]  CRC5_USB    = 5'h05;
  localparam logic [7:0]  CRC8        = 8'h07;
  localparam logic [15:0] CRC16_CCITT = 16'h1021;
  localparam logic [31:0] CRC32       = 32'h04C11DB7;
endpackage

// File: rtl/crc_lfsr_step.sv
// crc_lfsr_step: combinational single-bit Galois LFSR step
// lfsr: current register, data_bit: message bit, lfsr_next: register after the step
module crc_lfsr_step #(
  parameter int CRC_W = 5,
  parameter logic [CRC_W-1:0] POLY = CRC_W'(5'h05)
) (
  input  logic [CRC_W-1:0] lfsr,
  input  logic             data_bit,
  output logic [CRC_W-1:0] lfsr_next
);
  logic fb;
  assign fb = data_bit ^ lfsr[CRC_W-1];
  assign lfsr_next = {lfsr[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
endmodule

// File: rtl/crc_serial_engine.sv
// crc_serial_engine: bit-serial CRC generator/checker over a valid/ready word stream
// clk/reset: clock and sync active-high reset; clear: sync abort keeping crc_out
// in_valid/in_ready/data_in/in_last: word handshake, in_last closes the message
// crc_out/crc_valid/crc_ok: final remainder, one-cycle update pulse, zero-remainder flag
module crc_serial_engine import crc_pkg::*; #(
  parameter int CRC_W = 5,
  parameter logic [CRC_W-1:0] POLY = CRC_W'(5'h05),
  parameter int DATA_W = 4,
  parameter logic [CRC_W-1:0] INIT = '0,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic              in_last,
  output logic [CRC_W-1:0]  crc_out,
  output logic              crc_valid,
  output logic              crc_ok
);
  localparam int CW = $clog2(DATA_W) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_W - 1);
  crc_state_t state, state_next;
  logic [CRC_W-1:0] lfsr, lfsr_next;
  logic [DATA_W-1:0] word;
  logic [CW-1:0] cnt;
  logic last, data_bit, last_bit, done;
  crc_lfsr_step #(.CRC_W(CRC_W), .POLY(POLY)) u_step (
    .lfsr(lfsr),
    .data_bit(data_bit),
    .lfsr_next(lfsr_next)
  );
  // the word register shifts toward the output end, so the next bit is always at a fixed position
  assign data_bit = LSB_FIRST ? word[0] : word[DATA_W-1];
  assign in_ready = state == IDLE;
  assign last_bit = cnt == LAST_CNT;
  assign done = state == SHIFT && last_bit && last;
  always_comb begin
    state_next = state == IDLE ? (in_valid ? SHIFT : IDLE) : (last_bit ? IDLE : SHIFT);
  end
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state <= IDLE;
      lfsr <= INIT;
      cnt <= '0;
      crc_valid <= 1'b0;
      crc_ok <= 1'b0;
      if (reset) crc_out <= '0;
    end else begin
      state <= state_next;
      crc_valid <= done;
      crc_ok <= done && lfsr_next == '0;
      if (done) crc_out <= lfsr_next;
      if (in_ready && in_valid) begin
        word <= data_in;
        last <= in_last;
        cnt <= '0;
      end
      if (state == SHIFT) begin
        lfsr <= done ? INIT : lfsr_next;
        word <= LSB_FIRST ? word >> 1 : word << 1;
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_crc_serial_engine.sv
// tb_crc_serial_engine: directed self-checking bench for crc_serial_engine
module tb_crc_serial_engine;
  import crc_pkg::*;
  logic clk = 0, reset = 0, clear = 0;
  logic v4 = 0, l4 = 0;
  logic [3:0] d4 = '0;
  logic v8 = 0, l8 = 0;
  logic [7:0] d8 = '0;
  logic rdy_a, val_a, ok_a, rdy_b, val_b, ok_b, rdy_c, val_c, ok_c;
  logic [4:0] out_a, out_b;
  logic [7:0] out_c;
  int checks = 0, errors = 0;
  int n;
  logic seen;
  always #5 clk = ~clk;
  crc_serial_engine u_a (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(v4), .in_ready(rdy_a),
    .data_in(d4), .in_last(l4), .crc_out(out_a), .crc_valid(val_a), .crc_ok(ok_a)
  );
  crc_serial_engine #(.LSB_FIRST(1'b0)) u_b (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(v4), .in_ready(rdy_b),
    .data_in(d4), .in_last(l4), .crc_out(out_b), .crc_valid(val_b), .crc_ok(ok_b)
  );
  crc_serial_engine #(.CRC_W(8), .POLY(CRC8), .DATA_W(8), .LSB_FIRST(1'b0)) u_c (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(v8), .in_ready(rdy_c),
    .data_in(d8), .in_last(l8), .crc_out(out_c), .crc_valid(val_c), .crc_ok(ok_c)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic send4(input logic [3:0] d, input logic l);
    int k = 0;
    @(negedge clk);
    v4 = 1; d4 = d; l4 = l;
    while (!rdy_a && k < 50) begin @(negedge clk); k++; end
    chk("send4_ready", 32'(rdy_a), 32'd1);
    @(posedge clk);
    #1 v4 = 0;
  endtask
  task automatic wait_a(output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!val_a && cyc < 40);
  endtask
  task automatic idle_a(input int cyc, output logic hit);
    hit = 0;
    for (int i = 0; i < cyc; i++) begin @(negedge clk); if (val_a) hit = 1; end
  endtask
  initial begin
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_ready", 32'(rdy_a), 32'd1);
    chk("rst_out", 32'(out_a), 32'd0);
    chk("rst_valid", 32'(val_a), 32'd0);
    chk("rst_ok", 32'(ok_a), 32'd0);
    send4(4'h1, 1'b1);
    wait_a(n);
    chk("w1_latency", 32'(n), 32'd5);
    chk("w1_out", 32'(out_a), 32'h0D);
    chk("w1_ok", 32'(ok_a), 32'd0);
    @(negedge clk);
    chk("w1_pulse_len", 32'(val_a), 32'd0);
    send4(4'h1, 1'b0);
    idle_a(8, seen);
    chk("multi_no_mid_valid", 32'(seen), 32'd0);
    chk("multi_out_held", 32'(out_a), 32'h0D);
    send4(4'h0, 1'b1);
    wait_a(n);
    chk("multi_latency", 32'(n), 32'd5);
    chk("multi_out", 32'(out_a), 32'h0E);
    send4(4'h8, 1'b1);
    wait_a(n);
    chk("msb_b_valid", 32'(val_b), 32'd1);
    chk("msb_b_out", 32'(out_b), 32'h0D);
    chk("lsb_a_out_w8", 32'(out_a), 32'h05);
    @(negedge clk);
    v4 = 1; d4 = 4'h0; l4 = 1;
    @(posedge clk);
    #1 d4 = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_ready_low", 32'(rdy_a), 32'd0);
      d4 = 4'(4'hC + i);
    end
    @(negedge clk);
    chk("zero_valid", 32'(val_a), 32'd1);
    chk("zero_out", 32'(out_a), 32'd0);
    chk("zero_ok", 32'(ok_a), 32'd1);
    chk("zero_ready", 32'(rdy_a), 32'd1);
    d4 = 4'h1;
    @(posedge clk);
    #1 v4 = 0;
    wait_a(n);
    chk("b2b_latency", 32'(n), 32'd5);
    chk("b2b_out", 32'(out_a), 32'h0D);
    chk("b2b_ok", 32'(ok_a), 32'd0);
    send4(4'h0, 1'b1);
    @(negedge clk);
    clear = 1;
    @(posedge clk);
    #1 clear = 0;
    idle_a(8, seen);
    chk("clear_no_valid", 32'(seen), 32'd0);
    chk("clear_out_kept", 32'(out_a), 32'h0D);
    chk("clear_ready", 32'(rdy_a), 32'd1);
    send4(4'h1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_mid_ready", 32'(rdy_a), 32'd1);
    chk("rst_mid_out", 32'(out_a), 32'd0);
    idle_a(8, seen);
    chk("rst_mid_no_valid", 32'(seen), 32'd0);
    send4(4'h1, 1'b1);
    wait_a(n);
    chk("after_rst_out", 32'(out_a), 32'h0D);
    @(negedge clk);
    v8 = 1; d8 = 8'h31; l8 = 1;
    @(posedge clk);
    #1 d8 = 8'hAA;
    n = 0;
    do begin @(negedge clk); n++; end while (!val_c && n < 40);
    chk("crc8_latency", 32'(n), 32'd9);
    chk("crc8_out", 32'(out_c), 32'h97);
    chk("crc8_ok", 32'(ok_c), 32'd0);
    v8 = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
